// File: rtl/pot_shift_mac.sv
// pot_shift_mac: power-of-two weight multiply-accumulate engine.
// Each beat carries LANES activation/weight pairs. A weight code is
// {sign, exponent}; the lane product is the extended activation shifted
// left by the exponent, negated when sign=1 (sign=1 with exponent 0 is
// zero). VECTOR_LENGTH beats are summed into one signed result.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous abort of the vector in progress
//   in_valid/in_ready beat handshake (ready only while accumulating)
//   in_data, weight   packed per-lane activations and weight codes
//   out_valid/ready   result handshake
//   out_data          signed dot-product result
module pot_shift_mac #(
  parameter int WEIGHT_BIT_WIDTH = 4,
  parameter int INPUT_BIT_WIDTH  = 4,
  parameter int LANES            = 4,
  parameter int VECTOR_LENGTH    = 8,
  parameter int SIGNED_INPUT     = 0,
  localparam int PRODUCT_BIT_WIDTH = INPUT_BIT_WIDTH + 2**(WEIGHT_BIT_WIDTH-1),
  localparam int ACC_BIT_WIDTH     = PRODUCT_BIT_WIDTH + $clog2(LANES)
                                     + $clog2(VECTOR_LENGTH) + 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LANES*INPUT_BIT_WIDTH-1:0]    in_data,
  input  logic [LANES*WEIGHT_BIT_WIDTH-1:0]   weight,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [ACC_BIT_WIDTH-1:0]     out_data
);

  localparam int P_W   = PRODUCT_BIT_WIDTH;
  localparam int A_W   = ACC_BIT_WIDTH;
  localparam int EXP_W = WEIGHT_BIT_WIDTH - 1;
  localparam int CNT_W = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VECTOR_LENGTH - 1);

  typedef enum logic [1:0] {ACC, FLUSH, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     pv_q, pv_d;
  logic signed [P_W-1:0]    prod_q [LANES];
  logic signed [P_W-1:0]    prod_d [LANES];
  logic signed [A_W-1:0]    acc_q, acc_d;

  logic signed [P_W-1:0]    lane_prod [LANES];
  logic signed [A_W-1:0]    beat_sum;
  logic                     accept;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [INPUT_BIT_WIDTH-1:0]  act;
    logic [WEIGHT_BIT_WIDTH-1:0] code;
    logic [EXP_W-1:0]            shamt;
    logic                        fill;
    logic signed [P_W-1:0]       ext;
    logic signed [P_W-1:0]       shifted;

    assign act     = in_data[g*INPUT_BIT_WIDTH +: INPUT_BIT_WIDTH];
    assign code    = weight[g*WEIGHT_BIT_WIDTH +: WEIGHT_BIT_WIDTH];
    assign shamt   = code[EXP_W-1:0];
    assign fill    = (SIGNED_INPUT != 0) && act[INPUT_BIT_WIDTH-1];
    assign ext     = {{(P_W-INPUT_BIT_WIDTH){fill}}, act};
    assign shifted = ext << shamt;
    // Negative code with zero exponent is the dedicated zero weight.
    assign lane_prod[g] = !code[WEIGHT_BIT_WIDTH-1] ? shifted :
                          (shamt == '0)             ? '0      : -shifted;
  end

  always_comb begin
    beat_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      beat_sum = beat_sum + {{(A_W-P_W){prod_q[i][P_W-1]}}, prod_q[i]};
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pv_d    = pv_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    if (clear) begin
      state_d = ACC;
      cnt_d   = '0;
      pv_d    = 1'b0;
      acc_d   = '0;
    end else begin
      pv_d = accept;
      if (accept) prod_d = lane_prod;
      // Products of the previous beat land one cycle after registration,
      // so the last beat's products are folded in during FLUSH.
      if (pv_q) acc_d = acc_q + beat_sum;
      case (state_q)
        ACC: begin
          if (accept) begin
            if (cnt_q == LAST_BEAT) begin
              cnt_d   = '0;
              state_d = FLUSH;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        FLUSH: state_d = DONE;
        DONE: begin
          if (out_ready) begin
            state_d = ACC;
            acc_d   = '0;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      cnt_q   <= '0;
      pv_q    <= 1'b0;
      acc_q   <= '0;
      for (int unsigned i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pv_q    <= pv_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

endmodule
